mem_responder: RTL and testbench

Byte-addressed memory responder for the generated-core memory bus (`addr/size/valid/write/wdata/rdata/ready`). It is the target end of the interface that the C-to-HDL cores (e.g. quicksort, push/pop helpers) drive as initiators, and it replaces ad-hoc bench RAM with a synthesizable, checkable model. It adds configurable wait states, range/size error reporting, and a backdoor preload port for seeding data structures before a run.

---
 rtl/mem_rsp_pkg.sv | 26 ++
 rtl/mem_rsp_bytes.sv | 34 +++
 rtl/mem_responder.sv | 154 +++++++++++++++
 tb/tb_mem_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_rsp_pkg.sv
// Shared types for the memory responder: bus size codes, FSM states and a
// size-to-byte-count helper.
package mem_rsp_pkg;

    localparam logic [2:0] SZ_BYTE = 3'd0;
    localparam logic [2:0] SZ_HALF = 3'd1;
    localparam logic [2:0] SZ_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_GAP
    } state_t;

    // Illegal size codes report zero bytes; the caller flags them as errors.
    function automatic logic [2:0] nbytes(input logic [2:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_rsp_bytes.sv
// Byte storage for the memory responder: four independent byte-lane write
// ports and one 32-bit little-endian read port, all offsets relative to BASE.
module mem_rsp_bytes
    import mem_rsp_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int OFF_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic [3:0][OFF_W-1:0] wofs,
    input  logic [3:0][7:0]       wbyte,
    input  logic [OFF_W-1:0]      rofs,
    output logic [31:0]           rword
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we[k]) begin
                mem[wofs[k]] <= wbyte[k];
            end
        end
    end

    always_comb begin
        rword = '0;
        for (int k = 0; k < 4; k++) begin
            rword[8*k +: 8] = mem[rofs + OFF_W'(k)];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Target end of the generated-core memory bus: wait-state FSM, range/size
// checking, commit into byte storage and a backdoor word-preload port.
module mem_responder
    import mem_rsp_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'h1000,
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic        valid,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int          OFF_W     = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [32:0] LAST      = {1'b0, BASE} + 33'(DEPTH) - 33'd1;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        accept, commit;

    logic [31:0] addr_p1, wdata_p1;
    logic [2:0]  size_p1;
    logic        write_p1;

    logic [31:0] req_addr, req_wdata, lo, off, ld_off;
    logic [2:0]  req_size, n, span;
    logic        req_write, req_err, ld_ok;
    logic [32:0] last;

    logic [3:0]            we;
    logic [3:0][OFF_W-1:0] wofs;
    logic [3:0][7:0]       wbyte;
    logic [31:0]           rword;

    assign accept = (state == ST_IDLE) && valid && !ld_en;
    assign ready  = (state == ST_RESP);

    // With zero wait states the commit edge is also the accept edge, so the
    // live bus fields are used until the latched copy exists.
    always_comb begin
        req_addr  = (state == ST_IDLE) ? addr  : addr_p1;
        req_size  = (state == ST_IDLE) ? size  : size_p1;
        req_write = (state == ST_IDLE) ? write : write_p1;
        req_wdata = (state == ST_IDLE) ? wdata : wdata_p1;
        n         = nbytes(req_size);
        lo        = req_write ? req_addr : {req_addr[31:2], 2'b00};
        span      = req_write ? n : 3'd4;
        last      = {1'b0, lo} + 33'(span) - 33'd1;
        req_err   = (req_size > SZ_WORD) || (lo < BASE) || (last > LAST);
        off       = lo - BASE;
        ld_off    = ld_addr - BASE;
        ld_ok     = (ld_addr >= BASE) && (({1'b0, ld_addr} + 33'd3) <= LAST);
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    commit    = (WAIT_CYCLES == 0);
                end
            end
            ST_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nxt = ST_RESP;
                    commit    = 1'b1;
                end
            end
            ST_RESP: state_nxt = ST_GAP;
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        we    = '0;
        wofs  = '0;
        wbyte = '0;
        if ((state == ST_IDLE) && ld_en) begin
            for (int k = 0; k < 4; k++) begin
                we[k]    = ld_ok;
                wofs[k]  = ld_off[OFF_W-1:0] + OFF_W'(k);
                wbyte[k] = ld_data[8*k +: 8];
            end
        end else if (commit && req_write && !req_err) begin
            for (int k = 0; k < 4; k++) begin
                we[k]    = (3'(k) < n);
                wofs[k]  = off[OFF_W-1:0] + OFF_W'(k);
                wbyte[k] = req_wdata[8*k +: 8];
            end
        end
    end

    mem_rsp_bytes #(
        .DEPTH (DEPTH),
        .OFF_W (OFF_W)
    ) u_bytes (
        .clk   (clk),
        .we    (we),
        .wofs  (wofs),
        .wbyte (wbyte),
        .rofs  (off[OFF_W-1:0]),
        .rword (rword)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= WAIT_INIT;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                err <= req_err;
                if (req_err) begin
                    rdata <= '0;
                end else if (!req_write) begin
                    rdata <= rword;
                end
            end
        end
    end

    // Request latch is data only; it is never consulted outside a transaction.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1  <= addr;
            size_p1  <= size;
            write_p1 <= write;
            wdata_p1 <= wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder: one instance with no wait
// states and one with three, both compared against a byte-array model.
module tb_mem_responder;

    localparam logic [31:0] BASE  = 32'h1000;
    localparam int          DEPTH = 4096;

    logic        clk = 1'b0;
    logic [1:0]  rst_v;
    logic [31:0] addr, wdata, ld_addr, ld_data;
    logic [2:0]  size;
    logic        write;
    logic [1:0]  valid_v, ld_en_v, ready_v, err_v;
    logic [31:0] rdata_v [2];

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  mdl [2][DEPTH];
    logic [31:0] exp_rd [2];

    always #5 clk = ~clk;

    mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst_v[0]), .addr(addr), .size(size), .valid(valid_v[0]),
        .write(write), .wdata(wdata), .rdata(rdata_v[0]), .ready(ready_v[0]),
        .err(err_v[0]), .ld_en(ld_en_v[0]), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst_v[1]), .addr(addr), .size(size), .valid(valid_v[1]),
        .write(write), .wdata(wdata), .rdata(rdata_v[1]), .ready(ready_v[1]),
        .err(err_v[1]), .ld_en(ld_en_v[1]), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_ld(input int d, input logic [31:0] a, input logic [31:0] data);
        longint lo;
        lo = longint'(a);
        if (lo >= longint'(BASE) && lo + 3 <= longint'(BASE) + DEPTH - 1) begin
            for (int k = 0; k < 4; k++) mdl[d][int'(lo - longint'(BASE)) + k] = data[8*k +: 8];
        end
    endtask

    task automatic model_req(input int d, input logic [31:0] a, input logic [2:0] sz,
                             input logic wr, input logic [31:0] wd, output logic e);
        longint lo, nb;
        int     base_i;
        lo = wr ? longint'(a) : longint'(a & 32'hFFFF_FFFC);
        nb = wr ? (longint'(1) << sz) : 4;
        e  = (sz > 3'd2) || (lo < longint'(BASE)) || (lo + nb - 1 > longint'(BASE) + DEPTH - 1);
        if (e) begin
            exp_rd[d] = '0;
        end else begin
            base_i = int'(lo - longint'(BASE));
            if (wr) begin
                for (int k = 0; k < int'(nb); k++) mdl[d][base_i + k] = wd[8*k +: 8];
            end else begin
                exp_rd[d] = {mdl[d][base_i+3], mdl[d][base_i+2], mdl[d][base_i+1], mdl[d][base_i]};
            end
        end
    endtask

    task automatic do_ld(input int d, input logic [31:0] a, input logic [31:0] data);
        ld_addr    = a;
        ld_data    = data;
        ld_en_v[d] = 1'b1;
        model_ld(d, a, data);
        @(negedge clk);
        ld_en_v[d] = 1'b0;
    endtask

    // Issues one request at a negedge; the optional backdoor pulse collides with it.
    task automatic do_req(input int d, input logic [31:0] a, input logic [2:0] sz,
                          input logic wr, input logic [31:0] wd,
                          input bit with_ld, input logic [31:0] ld_a, input logic [31:0] ld_d);
        int   lat;
        bit   got;
        logic e;
        addr       = a;
        size       = sz;
        write      = wr;
        wdata      = wd;
        valid_v[d] = 1'b1;
        if (with_ld) begin
            ld_addr    = ld_a;
            ld_data    = ld_d;
            ld_en_v[d] = 1'b1;
            model_ld(d, ld_a, ld_d);
        end
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            ld_en_v[d] = 1'b0;
            lat++;
            got = ready_v[d];
        end
        valid_v[d] = 1'b0;
        model_req(d, a, sz, wr, wd, e);
        chk($sformatf("d%0d_latency a=%h", d, a), 32'(lat),
            32'((d == 0 ? 1 : 4) + (with_ld ? 1 : 0)));
        chk($sformatf("d%0d_err a=%h sz=%0d wr=%0d", d, a, sz, wr), 32'(err_v[d]), 32'(e));
        chk($sformatf("d%0d_rdata a=%h sz=%0d wr=%0d", d, a, sz, wr), rdata_v[d], exp_rd[d]);
        @(negedge clk);
        chk($sformatf("d%0d_ready_pulse", d), 32'(ready_v[d]), 32'd0);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom % 8)
            0:       return BASE - 32'($urandom_range(1, 8));
            1:       return BASE + 32'(DEPTH) - 32'($urandom_range(0, 8));
            2:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            default: return BASE + 32'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    initial begin
        int pulses;
        rst_v   = 2'b11;
        valid_v = '0;
        ld_en_v = '0;
        addr    = '0;
        size    = '0;
        write   = 1'b0;
        wdata   = '0;
        ld_addr = '0;
        ld_data = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_ready", d), 32'(ready_v[d]), 32'd0);
            chk($sformatf("d%0d_rst_err", d), 32'(err_v[d]), 32'd0);
            chk($sformatf("d%0d_rst_rdata", d), rdata_v[d], 32'd0);
        end
        rst_v = 2'b00;
        @(negedge clk);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH / 4; i++) do_ld(d, BASE + 32'(4 * i), $urandom);

        do_ld(0, 32'h1000, 32'h1122_3344);
        do_req(0, 32'h1002, 3'd2, 1'b0, 32'h0, 0, 32'h0, 32'h0);
        chk("tp_ld_read", rdata_v[0], 32'h1122_3344);

        do_ld(0, 32'h1004, 32'h0);
        do_req(0, 32'h1005, 3'd1, 1'b1, 32'hAABB_CCDD, 0, 32'h0, 32'h0);
        do_req(0, 32'h1004, 3'd2, 1'b0, 32'h0, 0, 32'h0, 32'h0);
        chk("tp_half_write", rdata_v[0], 32'h00CC_DD00);

        do_req(1, 32'h1FFF, 3'd0, 1'b1, 32'h0000_005A, 0, 32'h0, 32'h0);
        do_req(1, 32'h1FFC, 3'd0, 1'b0, 32'h0, 0, 32'h0, 32'h0);
        chk("tp_top_byte", 32'(rdata_v[1][31:24]), 32'h5A);

        do_req(0, 32'h1FFE, 3'd2, 1'b1, 32'hCAFE_F00D, 0, 32'h0, 32'h0);
        do_req(0, 32'h1FFC, 3'd2, 1'b0, 32'h0, 0, 32'h0, 32'h0);
        do_req(0, 32'h0FFC, 3'd2, 1'b0, 32'h0, 0, 32'h0, 32'h0);
        do_req(0, 32'h1000, 3'd3, 1'b0, 32'h0, 0, 32'h0, 32'h0);
        do_req(0, 32'hFFFF_FFFE, 3'd2, 1'b1, 32'h1234_5678, 0, 32'h0, 32'h0);
        do_req(0, 32'h1010, 3'd2, 1'b0, 32'h0, 1, 32'h1010, 32'h5566_7788);
        do_req(1, 32'h1020, 3'd2, 1'b0, 32'h0, 1, 32'h1020, 32'h99AA_BBCC);

        // Valid held through the GAP cycle must not cause a second issue.
        addr = 32'h1200; size = 3'd2; write = 1'b1; wdata = 32'h0BAD_F00D;
        valid_v[1] = 1'b1;
        pulses = 0;
        repeat (5) begin @(negedge clk); pulses += int'(ready_v[1]); end
        valid_v[1] = 1'b0;
        repeat (5) begin @(negedge clk); pulses += int'(ready_v[1]); end
        begin
            logic e;
            model_req(1, 32'h1200, 3'd2, 1'b1, 32'h0BAD_F00D, e);
        end
        chk("hold_valid_pulses", 32'(pulses), 32'd1);
        do_req(1, 32'h1200, 3'd2, 1'b0, 32'h0, 0, 32'h0, 32'h0);

        // Reset in WAIT aborts the write; a backdoor pulse in WAIT is dropped.
        addr = 32'h1100; size = 3'd2; write = 1'b1; wdata = 32'h1234_5678;
        valid_v[1] = 1'b1;
        @(negedge clk);
        ld_addr = 32'h1100; ld_data = 32'hDEAD_BEEF; ld_en_v[1] = 1'b1;
        @(negedge clk);
        ld_en_v[1] = 1'b0;
        rst_v[1]   = 1'b1;
        pulses = 0;
        @(negedge clk);
        pulses += int'(ready_v[1]);
        rst_v[1]   = 1'b0;
        valid_v[1] = 1'b0;
        repeat (6) begin @(negedge clk); pulses += int'(ready_v[1]); end
        chk("rst_abort_pulses", 32'(pulses), 32'd0);
        chk("rst_abort_rdata", rdata_v[1], 32'd0);
        chk("rst_abort_err", 32'(err_v[1]), 32'd0);
        exp_rd[1] = '0;
        do_req(1, 32'h1100, 3'd2, 1'b0, 32'h0, 0, 32'h0, 32'h0);

        for (int i = 0; i < 500; i++) begin
            logic [2:0] sz;
            sz = ($urandom % 8 < 6) ? 3'($urandom % 3) : 3'($urandom % 8);
            do_req(i % 2, rand_addr(), sz, 1'($urandom), $urandom, 0, 32'h0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
